mem_port_arbiter: RTL and testbench

- Shares the single downstream memory port between two requesters: instruction fetch (read-only) and the MEM-stage data access (read/write).
- Sits between if_stage / mem-stage address logic and the RAM helper.
- Gives the hazard unit a busy indication so the pipeline stalls while a fetch or a load is outstanding.
- Only one transaction is in flight at a time; request fields are registered toward memory.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_arb_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state and owner
// encodings, default bus widths, and the one-hot grant payload.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W  = 64;
    localparam int unsigned ARB_DATA_W  = 64;
    localparam int unsigned ARB_STATE_W = 2;
    localparam int unsigned ARB_CNT_W   = 3;

    // Arbiter FSM states
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_ISSUE = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_RESP  = 2'd2;

    // Owner of the transaction in flight
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // One-hot winner from the pick logic
    typedef struct packed {
        logic data;
        logic inst;
    } arb_gnt_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between fetch and data requests.
//   inst_req    in  fetch request pending
//   data_req    in  data request pending
//   starve_cnt  in  data grants made while fetch was waiting
//   gnt_c       out one-hot winner (all zero when nothing requests)
// Data wins a conflict unless the fetch side has waited STARVE_LIMIT grants.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 inst_req,
    input  logic                 data_req,
    input  logic [ARB_CNT_W-1:0] starve_cnt,
    output arb_gnt_t             gnt_c
);

    logic inst_first_c;

    // Winner selection; fetch only jumps the queue once starved
    always_comb begin
        inst_first_c = (starve_cnt >= ARB_CNT_W'(STARVE_LIMIT));
        gnt_c        = '0;
        if (data_req && !(inst_req && inst_first_c)) begin
            gnt_c.data = 1'b1;
        end else if (inst_req) begin
            gnt_c.inst = 1'b1;
        end
    end

endmodule : arb_pick

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (read-only) and the MEM-stage data access (read/write). One transaction
// is in flight at a time; request fields are registered toward memory and
// responses are registered back to the owning requester.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_req/inst_addr            fetch request (held until inst_gnt)
//   inst_gnt/inst_rvalid/rdata    fetch grant pulse, read data pulse
//   data_req/we/addr/wdata/wmask  data request (held until data_gnt)
//   data_gnt/data_rvalid/rdata    data grant pulse, load data or write ack
//   mem_req/we/addr/wdata/wmask   registered request to memory
//   mem_ready/mem_rvalid/rdata    memory handshake and read data
//   busy                          stall hint for the hazard unit
//   proto_err                     sticky: mem_rvalid seen outside RESP
//
// Optional feature macro: ARB_STARVE_GUARD_EN -- adds a saturating counter
// that lets fetch win a conflict after STARVE_LIMIT data grants in a row.
// Without it data always beats fetch on a conflict.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_wmask,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              proto_err
);

    logic [ARB_STATE_W-1:0] state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      mem_wmask_q, mem_wmask_d;
    logic                   inst_rvalid_q, inst_rvalid_d;
    logic [DATA_W-1:0]      inst_rdata_q, inst_rdata_d;
    logic                   data_rvalid_q, data_rvalid_d;
    logic [DATA_W-1:0]      data_rdata_q, data_rdata_d;
    logic                   proto_err_q, proto_err_d;

    logic [ARB_CNT_W-1:0]   starve_cnt;
    arb_gnt_t               pick_c;
    logic                   inst_win_c;
    logic                   data_win_c;

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve_cnt (starve_cnt),
        .gnt_c      (pick_c)
    );

    // Grants only happen from IDLE
    assign inst_win_c = (state_q == ARB_IDLE) & pick_c.inst;
    assign data_win_c = (state_q == ARB_IDLE) & pick_c.data;

`ifdef ARB_STARVE_GUARD_EN
    logic [ARB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Counts data grants that overtook a waiting fetch; saturates at all-ones
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (inst_win_c) begin
            starve_cnt_d = '0;
        end else if (data_win_c && inst_req && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + ARB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_cnt = starve_cnt_q;
`else
    assign starve_cnt = '0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        // Memory answering while nothing waits for it is a protocol fault
        proto_err_d   = proto_err_q | (mem_rvalid & (state_q != ARB_RESP));

        case (state_q)
            ARB_IDLE: begin
                if (inst_win_c || data_win_c) begin
                    owner_d     = data_win_c ? OWN_DATA : OWN_INST;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_win_c & data_we;
                    mem_addr_d  = data_win_c ? data_addr : inst_addr;
                    // Fetches carry no store payload
                    mem_wdata_d = data_win_c ? data_wdata : '0;
                    mem_wmask_d = data_win_c ? data_wmask : '0;
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        // Writes complete on acceptance; ack with zero data
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = '0;
                        state_d       = ARB_IDLE;
                    end else begin
                        state_d = ARB_RESP;
                    end
                end
            end
            ARB_RESP: begin
                if (mem_rvalid) begin
                    if (owner_q == OWN_DATA) begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = mem_rdata;
                    end else begin
                        inst_rvalid_d = 1'b1;
                        inst_rdata_d  = mem_rdata;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= OWN_INST;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Grants and busy are combinational; forced low while reset is held
    assign inst_gnt    = ~rst & inst_win_c;
    assign data_gnt    = ~rst & data_win_c;
    assign busy        = ~rst & ((state_q != ARB_IDLE) | inst_req | data_req);

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign inst_rvalid = inst_rvalid_q;
    assign inst_rdata  = inst_rdata_q;
    assign data_rvalid = data_rvalid_q;
    assign data_rdata  = data_rdata_q;
    assign proto_err   = proto_err_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [63:0] inst_addr;
    logic        inst_gnt, inst_rvalid;
    logic [63:0] inst_rdata;
    logic        data_req, data_we;
    logic [63:0] data_addr, data_wdata, data_wmask;
    logic        data_gnt, data_rvalid;
    logic [63:0] data_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_wmask;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy, proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_wmask  (data_wmask),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // At most one transaction is outstanding. It is first offered to memory
    // (until mem_ready) and, if a read, then waits for mem_rvalid.
    bit          m_out;
    bit          m_offered;
    bit          m_own_data;
    int unsigned m_waits;
    logic        e_mem_req, e_mem_we;
    logic [63:0] e_mem_addr, e_mem_wdata, e_mem_wmask;
    logic        e_irv, e_drv, e_perr;
    logic [63:0] e_ird, e_drd;

    always @(negedge clk) begin : model_chk
        logic w_inst, w_data, inst_turn;
`ifdef ARB_STARVE_GUARD_EN
        inst_turn = (m_waits >= 4);
`else
        inst_turn = 1'b0;
`endif
        if (rst) begin
            m_out = 0; m_offered = 0; m_own_data = 0; m_waits = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_wmask = '0;
            e_irv = 0; e_drv = 0; e_perr = 0; e_ird = '0; e_drd = '0;
            w_inst = 0; w_data = 0;
        end else begin
            w_data = !m_out && data_req && !(inst_req && inst_turn);
            w_inst = !m_out && inst_req && !w_data;
        end

        chk("inst_gnt", 64'(inst_gnt), 64'(w_inst));
        chk("data_gnt", 64'(data_gnt), 64'(w_data));
        chk("busy", 64'(busy), 64'(!rst && (m_out || inst_req || data_req)));
        chk("mem_req", 64'(mem_req), 64'(e_mem_req));
        if (e_mem_req) begin
            chk("mem_we", 64'(mem_we), 64'(e_mem_we));
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_wmask", mem_wmask, e_mem_wmask);
        end
        chk("inst_rvalid", 64'(inst_rvalid), 64'(e_irv));
        chk("inst_rdata", inst_rdata, e_ird);
        chk("data_rvalid", 64'(data_rvalid), 64'(e_drv));
        chk("data_rdata", data_rdata, e_drd);
        chk("proto_err", 64'(proto_err), 64'(e_perr));

        // Advance the model to what the coming clock edge must produce
        if (!rst) begin
            e_irv = 0;
            e_drv = 0;
            if (mem_rvalid && !(m_out && !m_offered)) e_perr = 1;
            if (!m_out) begin
                if (w_data || w_inst) begin
                    m_out = 1; m_offered = 1; m_own_data = w_data;
                    e_mem_req   = 1;
                    e_mem_we    = w_data && data_we;
                    e_mem_addr  = w_data ? data_addr : inst_addr;
                    e_mem_wdata = w_data ? data_wdata : 64'd0;
                    e_mem_wmask = w_data ? data_wmask : 64'd0;
                    if (w_data && inst_req) m_waits++;
                    if (w_inst) m_waits = 0;
                end
            end else if (m_offered) begin
                if (mem_ready) begin
                    e_mem_req = 0;
                    m_offered = 0;
                    if (e_mem_we) begin
                        e_drv = 1; e_drd = '0; m_out = 0;
                    end
                end
            end else if (mem_rvalid) begin
                if (m_own_data) begin e_drv = 1; e_drd = mem_rdata; end
                else            begin e_irv = 1; e_ird = mem_rdata; end
                m_out = 0;
            end
        end
    end

    // ---------------- memory responder / stimulus helpers ----------------
    logic        s_inst_gnt, s_data_gnt, s_accept;
    bit          mem_auto;
    bit          rd_pend;
    int unsigned rdy_pct, rv_pct, spur_pct;

    always @(negedge clk) begin
        s_inst_gnt = inst_gnt;
        s_data_gnt = data_gnt;
        s_accept   = mem_req && mem_ready && !mem_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (s_accept) rd_pend = 1'b1;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom(), $urandom()};
            if (rd_pend) begin
                if ($urandom_range(0, 99) < rv_pct) begin
                    mem_rvalid = 1'b1;
                    rd_pend    = 1'b0;
                end
            end else if ($urandom_range(0, 99) < spur_pct) begin
                mem_rvalid = 1'b1;
            end
            mem_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic rst_pulse();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int seq[6];
    int exp_seq[6];
    int ng;

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_we = 0; data_addr = '0; data_wdata = '0; data_wmask = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        mem_auto = 0; rd_pend = 0; rdy_pct = 100; rv_pct = 100; spur_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_proto_err", 64'(proto_err), 64'd0);
        rst = 1'b0;

        // Lone fetch
        mem_ready = 1; inst_req = 1; inst_addr = 64'h8000_0008;
        @(negedge clk); chk("lone_c0_inst_gnt", 64'(inst_gnt), 64'd1);
        step(); inst_req = 0;
        @(negedge clk); chk("lone_c1_mem_req", 64'(mem_req), 64'd1);
        chk("lone_c1_mem_addr", mem_addr, 64'h8000_0008);
        step(); mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk); chk("lone_c2_inst_rvalid", 64'(inst_rvalid), 64'd0);
        step(); mem_rvalid = 0;
        @(negedge clk); chk("lone_c3_inst_rvalid", 64'(inst_rvalid), 64'd1);
        chk("lone_c3_inst_rdata", inst_rdata, 64'h1111_2222_3333_4444);
        chk("lone_c3_data_rvalid", 64'(data_rvalid), 64'd0);
        step();

        // Conflict: data first, fetch once data has completed
        inst_req = 1; inst_addr = 64'h8000_0000;
        data_req = 1; data_we = 0; data_addr = 64'h8000_1000;
        @(negedge clk); chk("conf_data_gnt", 64'(data_gnt), 64'd1);
        chk("conf_inst_gnt0", 64'(inst_gnt), 64'd0);
        step(); data_req = 0;
        @(negedge clk); chk("conf_mem_addr_d", mem_addr, 64'h8000_1000);
        step(); mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk); chk("conf_inst_gnt_resp", 64'(inst_gnt), 64'd0);
        step(); mem_rvalid = 0;
        @(negedge clk); chk("conf_data_rvalid", 64'(data_rvalid), 64'd1);
        chk("conf_data_rdata", data_rdata, 64'hDEAD_BEEF_0BAD_F00D);
        chk("conf_inst_gnt", 64'(inst_gnt), 64'd1);
        step(); inst_req = 0;
        @(negedge clk); chk("conf_mem_addr_i", mem_addr, 64'h8000_0000);
        step(); mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        step(); mem_rvalid = 0;
        @(negedge clk); chk("conf_inst_rdata", inst_rdata, 64'h0123_4567_89AB_CDEF);
        step();

        // Store with memory stalling for 3 cycles
        data_req = 1; data_we = 1; data_addr = 64'h8000_2000;
        data_wdata = 64'hAAAA_BBBB_CCCC_DDDD; data_wmask = 64'h0000_0000_FFFF_0000;
        mem_ready = 0;
        @(negedge clk); chk("store_gnt", 64'(data_gnt), 64'd1);
        step(); data_req = 0; data_we = 0; data_wmask = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("store_mem_req", 64'(mem_req), 64'd1);
            chk("store_mem_we", 64'(mem_we), 64'd1);
            chk("store_mem_wmask", mem_wmask, 64'h0000_0000_FFFF_0000);
            chk("store_mem_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
            step();
        end
        mem_ready = 1;
        @(negedge clk); chk("store_ready_mem_req", 64'(mem_req), 64'd1);
        step();
        @(negedge clk); chk("store_ack", 64'(data_rvalid), 64'd1);
        chk("store_ack_rdata", data_rdata, 64'd0);
        chk("store_mem_req_low", 64'(mem_req), 64'd0);
        step();

        // Starvation: both requesters hold their request continuously
        mem_auto = 1; rd_pend = 0; rdy_pct = 100; rv_pct = 100; spur_pct = 0;
        mem_rvalid = 0; mem_ready = 1;
        inst_req = 1; inst_addr = 64'h8000_0100;
        data_req = 1; data_we = 0; data_addr = 64'h8000_3000;
`ifdef ARB_STARVE_GUARD_EN
        exp_seq = '{1, 1, 1, 1, 0, 1};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        seq = '{-1, -1, -1, -1, -1, -1};
        ng = 0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(negedge clk);
            if (data_gnt)      begin seq[ng] = 1; ng++; end
            else if (inst_gnt) begin seq[ng] = 0; ng++; end
            step();
        end
        inst_req = 0; data_req = 0;
        chk("starve_grant_count", 64'(ng), 64'd6);
        for (int i = 0; i < 6; i++) chk("starve_seq", 64'(seq[i]), 64'(exp_seq[i]));
        repeat (6) step();

        // Spurious mem_rvalid while idle
        mem_auto = 0; mem_ready = 0; mem_rvalid = 1;
        @(negedge clk); chk("spur_perr_before", 64'(proto_err), 64'd0);
        step(); mem_rvalid = 0;
        @(negedge clk); chk("spur_perr", 64'(proto_err), 64'd1);
        chk("spur_inst_rvalid", 64'(inst_rvalid), 64'd0);
        chk("spur_data_rvalid", 64'(data_rvalid), 64'd0);
        step(); step();
        @(negedge clk); chk("spur_perr_sticky", 64'(proto_err), 64'd1);
        rst_pulse();

        // Reset while waiting for read data
        mem_ready = 1; inst_req = 1; inst_addr = 64'h8000_4000;
        step(); inst_req = 0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_resp_busy", 64'(busy), 64'd0);
        chk("rst_resp_mem_addr", mem_addr, 64'd0);
        chk("rst_resp_inst_rdata", inst_rdata, 64'd0);
        step(); step();
        rst = 1'b0;
        mem_rvalid = 1; mem_rdata = 64'h5555_6666_7777_8888;
        step(); mem_rvalid = 0;
        @(negedge clk); chk("rst_resp_perr", 64'(proto_err), 64'd1);
        chk("rst_resp_no_rvalid", 64'(inst_rvalid), 64'd0);
        rst_pulse();

        // Randomized traffic
        mem_auto = 1; rd_pend = 0; rdy_pct = 60; rv_pct = 40; spur_pct = 0;
        for (int c = 0; c < 3500; c++) begin
            if (c == 3000) spur_pct = 2;
            step();
            if (inst_req && s_inst_gnt) inst_req = 0;
            if (data_req && s_data_gnt) data_req = 0;
            if (!inst_req) begin
                if ($urandom_range(0, 99) < 35) begin
                    inst_req  = 1;
                    inst_addr = {$urandom(), $urandom()};
                end
            end else if ($urandom_range(0, 99) < 4) begin
                inst_req = 0;
            end
            if (!data_req) begin
                if ($urandom_range(0, 99) < 40) begin
                    data_req   = 1;
                    data_we    = $urandom_range(0, 1) == 1;
                    data_addr  = {$urandom(), $urandom()};
                    data_wdata = {$urandom(), $urandom()};
                    data_wmask = {$urandom(), $urandom()};
                end
            end else if ($urandom_range(0, 99) < 4) begin
                data_req = 0;
            end
        end
        inst_req = 0; data_req = 0;
        spur_pct = 0; rdy_pct = 100; rv_pct = 100;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
